// File: rtl/seq_subtractor_param.sv
// rtl/seq_subtractor_param.sv - multi-cycle chunked subtractor D = A - B - B_in with start/ready/done handshake
// Optional V/Z flag outputs are enabled by defining SEQ_SUB_FLAGS_EN.
module seq_subtractor_param #(
    parameter int W     = 128,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         B_in,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] D,
    output logic         B_out
`ifdef SEQ_SUB_FLAGS_EN
    ,
    output logic         V,
    output logic         Z
`endif
);

    localparam int N     = W / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     d_q, d_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;

    logic [31:0]      base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   diff;
    logic             last;

`ifdef SEQ_SUB_FLAGS_EN
    logic v_q, v_d;
    logic z_q, z_d;
    logic zacc_q, zacc_d;
`endif

    // Single chunk-wide subtract; the MSB of the CHUNK+1 result is the borrow out.
    assign base    = 32'(idx_q) * 32'(CHUNK);
    assign a_chunk = a_q[base +: CHUNK];
    assign b_chunk = b_q[base +: CHUNK];
    assign diff    = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, br_q};
    assign last    = (idx_q == IDX_W'(N - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        br_d    = br_q;
        bout_d  = bout_q;
        done_d  = 1'b0;
`ifdef SEQ_SUB_FLAGS_EN
        v_d     = v_q;
        z_d     = z_q;
        zacc_d  = zacc_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = B_in;
                    d_d     = '0;
                    bout_d  = 1'b0;
                    idx_d   = '0;
                    state_d = RUN;
`ifdef SEQ_SUB_FLAGS_EN
                    v_d     = 1'b0;
                    z_d     = 1'b0;
                    zacc_d  = 1'b1;
`endif
                end
            end
            RUN: begin
                d_d[base +: CHUNK] = diff[CHUNK-1:0];
                br_d               = diff[CHUNK];
`ifdef SEQ_SUB_FLAGS_EN
                zacc_d = zacc_q & (diff[CHUNK-1:0] == '0);
`endif
                if (last) begin
                    bout_d  = diff[CHUNK];
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
`ifdef SEQ_SUB_FLAGS_EN
                    // diff[CHUNK-1] of the top chunk is the sign bit of the result.
                    v_d = (a_q[W-1] != b_q[W-1]) & (diff[CHUNK-1] != a_q[W-1]);
                    z_d = zacc_d;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
        end
    end

`ifdef SEQ_SUB_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= 1'b0;
            z_q    <= 1'b0;
            zacc_q <= 1'b0;
        end else begin
            v_q    <= v_d;
            z_q    <= z_d;
            zacc_q <= zacc_d;
        end
    end

    assign V = v_q;
    assign Z = z_q;
`endif

    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign D     = d_q;
    assign B_out = bout_q;

endmodule

// File: tb/tb_seq_subtractor_param.sv
// tb/tb_seq_subtractor_param.sv - scoreboard bench for seq_subtractor_param against an arithmetic reference model
module tb_seq_subtractor_param;

    localparam int W     = 128;
    localparam int CHUNK = 8;
    localparam int N     = W / CHUNK;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         B_in  = 1'b0;
    logic         ready;
    logic         done;
    logic [W-1:0] D;
    logic         B_out;
`ifdef SEQ_SUB_FLAGS_EN
    logic         V;
    logic         Z;
`endif

    seq_subtractor_param #(.W(W), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .B_in  (B_in),
        .ready (ready),
        .done  (done),
        .D     (D),
        .B_out (B_out)
`ifdef SEQ_SUB_FLAGS_EN
        ,
        .V     (V),
        .Z     (Z)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         v;
        logic         z;
        int           cyc;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         e;
    int           busy   = 0;
    int           cyc    = 0;
    int           n_vec  = 0;
    int           n_err  = 0;
    logic [W-1:0] last_d = '0;
    logic         last_bo = 1'b0;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic bin, input int c);
        exp_t     r;
        logic [W:0] full;
        full  = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
        r.d   = full[W-1:0];
        r.bo  = full[W];
        r.v   = (a[W-1] != b[W-1]) && (r.d[W-1] != a[W-1]);
        r.z   = (r.d == '0);
        r.cyc = c;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0: r = '0;
            1: r = '1;
            2: r = r & 128'hFF;
            default: ;
        endcase
        return r;
    endfunction

    // Acceptance model: an operation occupies the block for N edges after the accepting edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            busy <= 0;
            exp_q.delete();
        end else if (busy == 0 && start) begin
            exp_q.push_back(model(A, B, B_in, cyc + 1));
            busy <= N;
        end else if (busy > 0) begin
            busy <= busy - 1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            last_d  = '0;
            last_bo = 1'b0;
        end else begin
            chk("ready", W'(ready), W'(busy == 0));
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", W'(done), '0);
                end else begin
                    e = exp_q.pop_front();
                    chk("D", D, e.d);
                    chk("B_out", W'(B_out), W'(e.bo));
                    chk("latency", W'(cyc - e.cyc), W'(N));
`ifdef SEQ_SUB_FLAGS_EN
                    chk("V", W'(V), W'(e.v));
                    chk("Z", W'(Z), W'(e.z));
`endif
                    last_d  = e.d;
                    last_bo = e.bo;
                end
            end else if (busy == 0) begin
                chk("D_held", D, last_d);
                chk("B_out_held", W'(B_out), W'(last_bo));
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 4 * N && (exp_q.size() != 0 || busy != 0); i++) begin
            @(negedge clk);
            #2;
        end
        chk("drain_timeout", W'(exp_q.size()), '0);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        @(negedge clk);
        #1;
        start = 1'b1;
        A     = a;
        B     = b;
        B_in  = bin;
        @(negedge clk);
        #1;
        start = 1'b0;
        A     = rnd();
        B     = rnd();
        B_in  = 1'(($urandom() & 1));
        wait_idle();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_D", D, '0);
        chk("rst_B_out", W'(B_out), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_ready", W'(ready), W'(1));
        rst = 1'b0;

        op(128'd5, 128'd3, 1'b0);
        op(128'd0, 128'd1, 1'b0);
        op(128'd0, 128'd0, 1'b1);
        op(128'd1 << 64, 128'd1, 1'b0);
        op(128'd1 << 127, 128'd1, 1'b0);
        op(128'hDEAD, 128'hDEAD, 1'b0);
        op('1, '1, 1'b1);

        for (int i = 0; i < 40; i++) op(rnd(), rnd(), 1'(($urandom() & 1)));

        // Continuous start with operands changing every cycle.
        @(negedge clk);
        #1;
        start = 1'b1;
        for (int i = 0; i < 600 * (N + 1); i++) begin
            A    = rnd();
            B    = rnd();
            B_in = 1'(($urandom() & 1));
            @(negedge clk);
            #1;
        end
        start = 1'b0;
        wait_idle();

        // Abort mid-operation with an asynchronous reset.
        @(negedge clk);
        #1;
        start = 1'b1;
        A     = {$urandom(), $urandom(), $urandom(), $urandom()} | 128'h1;
        B     = 128'h0;
        B_in  = 1'b0;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_D", D, '0);
        chk("abort_B_out", W'(B_out), '0);
        chk("abort_done", W'(done), '0);
        chk("abort_ready", W'(ready), W'(1));
        @(negedge clk);
        #1;
        rst = 1'b0;
        op(128'd100, 128'd58, 1'b0);
        chk("post_abort_D", D, 128'd42);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
